// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcodes, IR field positions,
// sequencer states and the instruction classes produced by cu_decode.
package cpu_pkg;

   localparam int IR_OP_HI = 31;
   localparam int IR_OP_LO = 27;
   localparam int IR_RA_HI = 26;
   localparam int IR_RA_LO = 23;
   localparam int IR_RB_HI = 22;
   localparam int IR_RB_LO = 19;
   localparam int IR_RC_HI = 18;
   localparam int IR_RC_LO = 15;

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_SHR  = 5'b00111,
      OP_SHRA = 5'b01000,
      OP_SHL  = 5'b01001,
      OP_ROR  = 5'b01010,
      OP_ROL  = 5'b01011,
      OP_MUL  = 5'b01111,
      OP_DIV  = 5'b10000,
      OP_MFHI = 5'b10111,
      OP_MFLO = 5'b11000,
      OP_NOP  = 5'b11001,
      OP_HALT = 5'b11010
   } cu_op_t;

   typedef enum logic [3:0] {
      ST_RST,
      ST_T0,
      ST_T1,
      ST_T1W,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HLT
   } cu_state_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_MULDIV,
      CLS_MOVE,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } cu_class_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-class decoder; shared by the sequencer and by
// later instruction classes.
module cu_decode
   import cpu_pkg::*;
(
   input  logic [4:0] op_i,
   output cu_class_t  cls_o
);

   always_comb begin
      cls_o = CLS_ILLEGAL;
      if (op_i >= OP_ADD && op_i <= OP_ROL) begin
         cls_o = CLS_ALU;
      end else begin
         case (op_i)
            OP_MUL, OP_DIV:   cls_o = CLS_MULDIV;
            OP_MFHI, OP_MFLO: cls_o = CLS_MOVE;
            OP_NOP:           cls_o = CLS_NOP;
            OP_HALT:          cls_o = CLS_HALT;
            default:          cls_o = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the single-bus datapath (fetch T0-T2, execute T3-T6).
// Define CU_ILLEGAL_TRAP_EN to halt on undefined opcodes and expose the sticky illegal flag.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_done,
   output logic        PCout,
   output logic        MARin,
   output logic        incPC,
   output logic        Zin,
   output logic        ZLowOut,
   output logic        ZHighOut,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        HIout,
   output logic        LOout,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic [4:0]  opcode,
   output logic        run
`ifdef CU_ILLEGAL_TRAP_EN
   ,
   output logic        illegal
`endif
);

   cu_state_t  state_q, state_d;
   cu_class_t  cls_ir, cls_q, cls_d;
   logic [4:0] op_ir, op_q, op_d;
   logic       unused_ir_fields;
`ifdef CU_ILLEGAL_TRAP_EN
   logic       illegal_q;
`endif

   assign op_ir = ir[IR_OP_HI:IR_OP_LO];
   // Register fields are routed by the datapath itself via Gra/Grb/Grc.
   assign unused_ir_fields = ^{ir[IR_RA_HI:IR_RA_LO], ir[IR_RB_HI:IR_RB_LO],
                               ir[IR_RC_HI:IR_RC_LO], ir[IR_RC_LO-1:0]};

   cu_decode u_decode (
      .op_i  (op_ir),
      .cls_o (cls_ir)
   );

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      op_d    = op_q;
      case (state_q)
         ST_RST:  state_d = ST_T0;
         ST_T0:   state_d = ST_T1;
         ST_T1,
         ST_T1W:  state_d = mem_done ? ST_T2 : ST_T1W;
         ST_T2:   state_d = ST_T3;
         ST_T3: begin
            cls_d = cls_ir;
            op_d  = op_ir;
            case (cls_ir)
               CLS_ALU, CLS_MULDIV: state_d = ST_T4;
               CLS_HALT:            state_d = ST_HLT;
`ifdef CU_ILLEGAL_TRAP_EN
               CLS_ILLEGAL:         state_d = ST_HLT;
`endif
               default:             state_d = ST_T0;
            endcase
         end
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = (cls_q == CLS_MULDIV) ? ST_T6 : ST_T0;
         ST_T6:   state_d = ST_T0;
         ST_HLT:  state_d = ST_HLT;
         default: state_d = ST_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= ST_RST;
         cls_q     <= CLS_NOP;
         op_q      <= 5'd0;
`ifdef CU_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         op_q      <= op_d;
`ifdef CU_ILLEGAL_TRAP_EN
         if (state_q == ST_T3 && cls_ir == CLS_ILLEGAL) illegal_q <= 1'b1;
`endif
      end
   end

`ifdef CU_ILLEGAL_TRAP_EN
   assign illegal = illegal_q;
`endif

   // T3 decodes the live IR; T4 onward uses the class/op captured at the end of T3.
   always_comb begin
      {PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout, IRin,
       Yin, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout} = 21'd0;
      opcode = 5'd0;
      run    = (state_q != ST_RST) && (state_q != ST_HLT);
      case (state_q)
         ST_T0: begin
            PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
         end
         ST_T1: begin
            ZLowOut = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         ST_T1W: begin
            Read = 1'b1; MDRin = 1'b1;
         end
         ST_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         ST_T3: begin
            case (cls_ir)
               CLS_ALU:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               CLS_MOVE: begin
                  HIout = (op_ir == OP_MFHI);
                  LOout = (op_ir == OP_MFLO);
                  Gra   = 1'b1;
                  Rin   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            Rout   = 1'b1;
            Zin    = 1'b1;
            opcode = op_q;
            if (cls_q == CLS_MULDIV) Grb = 1'b1;
            else                     Grc = 1'b1;
         end
         ST_T5: begin
            ZLowOut = 1'b1;
            if (cls_q == CLS_MULDIV) begin
               LOin = 1'b1;
            end else begin
               Gra = 1'b1;
               Rin = 1'b1;
            end
         end
         ST_T6: begin
            ZHighOut = 1'b1; HIin = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected strobe traces built
// from the instruction-class timing tables. Honours CU_ILLEGAL_TRAP_EN.
`timescale 1ns/1ps
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] ir;
   logic        mem_done;
   logic        PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout, IRin;
   logic        Yin, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout;
   logic [4:0]  opcode;
   logic        run;
`ifdef CU_ILLEGAL_TRAP_EN
   logic        illegal;
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   always #5 clk = ~clk;

   control_unit dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_done(mem_done),
      .PCout(PCout), .MARin(MARin), .incPC(incPC), .Zin(Zin), .ZLowOut(ZLowOut),
      .ZHighOut(ZHighOut), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
      .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .opcode(opcode), .run(run)
`ifdef CU_ILLEGAL_TRAP_EN
      , .illegal(illegal)
`endif
   );

   // One bit per strobe, in the order of the observation vector below.
   localparam logic [20:0] S_PCOUT = 21'h100000, S_MARIN = 21'h080000, S_INCPC  = 21'h040000,
                           S_ZIN   = 21'h020000, S_ZLO   = 21'h010000, S_ZHI    = 21'h008000,
                           S_PCIN  = 21'h004000, S_READ  = 21'h002000, S_MDRIN  = 21'h001000,
                           S_MDROUT= 21'h000800, S_IRIN  = 21'h000400, S_YIN    = 21'h000200,
                           S_HIIN  = 21'h000100, S_LOIN  = 21'h000080, S_HIOUT  = 21'h000040,
                           S_LOOUT = 21'h000020, S_GRA   = 21'h000010, S_GRB    = 21'h000008,
                           S_GRC   = 21'h000004, S_RIN   = 21'h000002, S_ROUT   = 21'h000001;
   localparam logic [26:0] T0V = {S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'd0, 1'b1};
   localparam logic [26:0] ZV  = 27'd0;

   logic [20:0] strobes;
   assign strobes = {PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout,
                     IRin, Yin, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout};

   int checks = 0;
   int errors = 0;

   logic [26:0] exp_q[$];
   logic [31:0] irq[$];
   logic        mdq[$];

   function automatic bit op_defined(input logic [4:0] op);
      return (op >= 5'd3 && op <= 5'd11) || (op inside {5'd15, 5'd16, 5'd23, 5'd24, 5'd25, 5'd26});
   endfunction

   function automatic void push(input logic [20:0] s, input logic [4:0] op, input logic r,
                                input logic [31:0] irv, input logic md);
      exp_q.push_back({s, op, r});
      irq.push_back(irv);
      mdq.push_back(md);
   endfunction

   // Expected per-cycle trace from T0 of one instruction up to (not including) the next T0.
   // Fetch cycles drive junk on ir; a halting instruction is followed by halt_len HLT cycles.
   function automatic bit build_trace(input logic [31:0] instr, input int stall, input int halt_len);
      logic [4:0] op;
      bit         halts;
      op = instr[31:27];
      exp_q.delete(); irq.delete(); mdq.delete();
      push(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 5'd0, 1'b1, $urandom, 1'($urandom));
      push(S_ZLO | S_PCIN | S_READ | S_MDRIN, 5'd0, 1'b1, $urandom, stall == 0);
      for (int j = 1; j <= stall; j++) push(S_READ | S_MDRIN, 5'd0, 1'b1, $urandom, j == stall);
      push(S_MDROUT | S_IRIN, 5'd0, 1'b1, $urandom, 1'($urandom));
      if (op >= 5'd3 && op <= 5'd11) begin
         push(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, instr, 1'($urandom));
         push(S_GRC | S_ROUT | S_ZIN, op, 1'b1, instr, 1'($urandom));
         push(S_ZLO | S_GRA | S_RIN, 5'd0, 1'b1, instr, 1'($urandom));
      end else if (op == 5'd15 || op == 5'd16) begin
         push(S_GRA | S_ROUT | S_YIN, 5'd0, 1'b1, instr, 1'($urandom));
         push(S_GRB | S_ROUT | S_ZIN, op, 1'b1, instr, 1'($urandom));
         push(S_ZLO | S_LOIN, 5'd0, 1'b1, instr, 1'($urandom));
         push(S_ZHI | S_HIIN, 5'd0, 1'b1, instr, 1'($urandom));
      end else if (op == 5'd23) begin
         push(S_HIOUT | S_GRA | S_RIN, 5'd0, 1'b1, instr, 1'($urandom));
      end else if (op == 5'd24) begin
         push(S_LOOUT | S_GRA | S_RIN, 5'd0, 1'b1, instr, 1'($urandom));
      end else begin
         push(21'd0, 5'd0, 1'b1, instr, 1'($urandom));
      end
      halts = (op == 5'd26) || (TRAP && !op_defined(op));
      if (halts) for (int j = 0; j < halt_len; j++) push(21'd0, 5'd0, 1'b0, $urandom, 1'($urandom));
      return halts;
   endfunction

   task automatic step(input logic [31:0] ir_v, input logic md_v, output logic [26:0] o);
      ir       = ir_v;
      mem_done = md_v;
      #1;
      o = {strobes, opcode, run};
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [26:0] o;
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== ZV) begin errors++; $display("FAIL reset_state: got %h expected %h", o, ZV); end
`ifdef CU_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
`endif
      clr = 1'b0;
      @(posedge clk); #1; #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL reset_to_t0: got %h expected %h", o, T0V); end
   endtask

   task automatic test_add();
      logic [26:0] o;
      void'(build_trace(32'h18918000, 0, 0));
      for (int k = 0; k < exp_q.size(); k++) begin
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL add cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL add_loop6: got %h expected %h", o, T0V); end
   endtask

   task automatic test_div();
      logic [26:0] o;
      void'(build_trace({5'b10000, 4'd2, 4'd3, 4'd0, 15'd0}, 0, 0));
      for (int k = 0; k < exp_q.size(); k++) begin
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL div cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL div_loop7: got %h expected %h", o, T0V); end
   endtask

   task automatic test_mem_stall();
      logic [26:0] o;
      void'(build_trace({5'b00100, 27'($urandom)}, 3, 0));
      for (int k = 0; k < exp_q.size(); k++) begin
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL stall cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL stall_end_t0: got %h expected %h", o, T0V); end
      // Reset while waiting on memory (second T1W cycle).
      void'(build_trace({5'b00011, 27'($urandom)}, 3, 0));
      for (int k = 0; k <= 3; k++) begin
         if (k == 3) clr = 1'b1;
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL stall_abort cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
      clr = 1'b0;
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== ZV) begin errors++; $display("FAIL stall_abort_rst: got %h expected %h", o, ZV); end
      @(posedge clk); #1; #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL stall_abort_t0: got %h expected %h", o, T0V); end
   endtask

   task automatic test_reset_mid_mul();
      logic [26:0] o;
      void'(build_trace({5'b01111, 27'($urandom)}, 0, 0));
      for (int k = 0; k <= 4; k++) begin
         if (k == 4) clr = 1'b1;
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL mul_abort cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
      clr = 1'b0;
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== ZV) begin errors++; $display("FAIL mul_abort_rst: got %h expected %h", o, ZV); end
      @(posedge clk); #1; #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL mul_abort_t0: got %h expected %h", o, T0V); end
   endtask

   task automatic test_halt();
      logic [26:0] o;
      bit          h;
      h = build_trace({5'b11010, 27'($urandom)}, 1, 20);
      checks++;
      if (!h) begin errors++; $display("FAIL halt_model: got %b expected 1", h); end
      for (int k = 0; k < exp_q.size(); k++) begin
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL halt cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== ZV) begin errors++; $display("FAIL halt_clr_rst: got %h expected %h", o, ZV); end
      @(posedge clk); #1; #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL halt_clr_t0: got %h expected %h", o, T0V); end
   endtask

   task automatic test_illegal();
      logic [26:0] o;
      bit          h;
      h = build_trace({5'b11111, 27'($urandom)}, 0, 5);
      for (int k = 0; k < exp_q.size(); k++) begin
         step(irq[k], mdq[k], o);
         checks++;
         if (o !== exp_q[k]) begin errors++; $display("FAIL illegal cyc%0d: got %h expected %h", k, o, exp_q[k]); end
      end
`ifdef CU_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", illegal); end
`endif
      if (h) begin
         clr = 1'b1;
         @(posedge clk); #1;
         clr = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
         checks++;
         if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clr: got %b expected 0", illegal); end
`endif
         @(posedge clk); #1;
      end
      #1;
      o = {strobes, opcode, run};
      checks++;
      if (o !== T0V) begin errors++; $display("FAIL illegal_t0: got %h expected %h", o, T0V); end
   endtask

   task automatic test_back_to_back();
      logic [26:0] o;
      logic [4:0]  op;
      logic [4:0]  ops [15] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                5'd15, 5'd16, 5'd23, 5'd24, 5'd25, 5'd26};
      bit          h;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) op = 5'($urandom);
         else                           op = ops[$urandom_range(0, 14)];
         h = build_trace({op, 27'($urandom)}, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 3);
         for (int k = 0; k < exp_q.size(); k++) begin
            step(irq[k], mdq[k], o);
            checks++;
            if (o !== exp_q[k]) begin
               errors++;
               $display("FAIL b2b n%0d op%0d cyc%0d: got %h expected %h", n, op, k, o, exp_q[k]);
            end
         end
         if (h) begin
`ifdef CU_ILLEGAL_TRAP_EN
            checks++;
            if (illegal !== !op_defined(op)) begin
               errors++; $display("FAIL b2b_illegal n%0d: got %b expected %b", n, illegal, !op_defined(op));
            end
`endif
            clr = 1'b1;
            @(posedge clk); #1;
            clr = 1'b0;
            @(posedge clk); #1;
         end
         #1;
         o = {strobes, opcode, run};
         checks++;
         if (o !== T0V) begin errors++; $display("FAIL b2b_t0 n%0d: got %h expected %h", n, o, T0V); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "watchdog");
   end

   initial begin
      clr      = 1'b1;
      ir       = 32'd0;
      mem_done = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_add();
      test_div();
      test_mem_stall();
      test_reset_mid_mul();
      test_halt();
      test_illegal();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
